// File: rtl/store_queue_ctrl.sv
// Store queue between the MEM stage and the 64-bit data memory write port.
// Sizes and lane-aligns stores, buffers them in a FIFO, and supports fence/drain.
module store_queue_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     st_valid,
    output logic                     st_ready,
    input  logic [1:0]               st_size,
    input  logic [63:0]              st_addr,
    input  logic [63:0]              st_data,
    output logic                     mem_req,
    input  logic                     mem_ack,
    output logic [63:0]              mem_addr,
    output logic [63:0]              mem_wdata,
    output logic [7:0]               mem_be,
    input  logic [63:0]              ld_addr,
    output logic                     ld_hazard,
    input  logic                     fence_req,
    output logic                     fence_done,
    output logic                     err_misalign,
    output logic [63:0]              err_addr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    localparam logic [1:0] SPL_SB = 2'd0;
    localparam logic [1:0] SPL_SH = 2'd1;
    localparam logic [1:0] SPL_SW = 2'd2;
    localparam logic [1:0] SPL_SD = 2'd3;

    typedef enum logic [1:0] {IDLE, RUN, FENCE, DONE} state_e;

    state_e state, state_next;

    logic [63:0]      q_addr  [DEPTH];
    logic [63:0]      q_wdata [DEPTH];
    logic [7:0]       q_be    [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [AW-1:0]    wr_ptr, rd_ptr;

    logic        misalign;
    logic [63:0] sized;
    logic [7:0]  be_base;
    logic        accept, push, pop;
    logic        unused_bits;

    assign unused_bits = ^ld_addr[2:0];

    // Size mask and alignment rule per store size.
    always_comb begin
        sized    = st_data;
        be_base  = 8'hFF;
        misalign = 1'b0;
        case (st_size)
            SPL_SB: begin
                sized   = {56'd0, st_data[7:0]};
                be_base = 8'h01;
            end
            SPL_SH: begin
                sized    = {48'd0, st_data[15:0]};
                be_base  = 8'h03;
                misalign = st_addr[0];
            end
            SPL_SW: begin
                sized    = {32'd0, st_data[31:0]};
                be_base  = 8'h0F;
                misalign = |st_addr[1:0];
            end
            default: misalign = |st_addr[2:0];
        endcase
    end

    assign st_ready = (count != FULL) && (state != FENCE);
    assign accept   = st_valid && st_ready;
    assign push     = accept && !misalign;
    assign mem_req  = (count != '0) && (state != IDLE);
    assign pop      = mem_req && mem_ack;

    assign mem_addr   = q_addr[rd_ptr];
    assign mem_wdata  = q_wdata[rd_ptr];
    assign mem_be     = q_be[rd_ptr];
    assign fence_done = (state == DONE);

    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_addr[i][63:3] == ld_addr[63:3])) ld_hazard = 1'b1;
        end
    end

    // A push in the same cycle as the fence keeps the fence from completing early.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  state_next = RUN;
            RUN:   if (fence_req) state_next = (count == '0 && !push) ? DONE : FENCE;
            FENCE: if (count == '0 || (count == 1 && pop)) state_next = DONE;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            q_valid      <= '0;
            err_misalign <= 1'b0;
            err_addr     <= '0;
        end else begin
            state        <= state_next;
            err_misalign <= accept && misalign;
            if (accept && misalign) err_addr <= st_addr;
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                q_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr          <= wr_ptr + 1'b1;
                q_valid[wr_ptr] <= 1'b1;
            end
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    // NOTE: entry payloads need no reset; q_valid and count decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr]  <= {st_addr[63:3], 3'b000};
            q_wdata[wr_ptr] <= sized << {st_addr[2:0], 3'b000};
            q_be[wr_ptr]    <= be_base << st_addr[2:0];
        end
    end

endmodule
